// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and FSM state type for the ALU issue stage.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 4;

  // Opcodes are forwarded untouched; the ALU defines what each one does.
  localparam logic [SEL_W_DEF-1:0] SEL_OP1 = 4'd1;
  localparam logic [SEL_W_DEF-1:0] SEL_OP2 = 4'd2;
  localparam logic [SEL_W_DEF-1:0] SEL_OP3 = 4'd3;
  localparam logic [SEL_W_DEF-1:0] SEL_OP4 = 4'd4;
  localparam logic [SEL_W_DEF-1:0] SEL_OP5 = 4'd5;
  localparam logic [SEL_W_DEF-1:0] SEL_OP6 = 4'd6;
  localparam logic [SEL_W_DEF-1:0] SEL_OP7 = 4'd7;
  localparam logic [SEL_W_DEF-1:0] SEL_OP8 = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-drive and response signals of the issue stage, bundled as one interface.
interface alu_issue_if #(
  parameter int DATA_W = alu_pkg::DATA_W_DEF,
  parameter int SEL_W  = alu_pkg::SEL_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [SEL_W-1:0]  cmd_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [SEL_W-1:0]  rsp_sel;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_sel
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_sel
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Registered command FIFO; the extra count bit separates full from empty.
module alu_cmd_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: buffers commands, drives one at a time into the ALU and
// returns each captured result over a valid/ready response port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);
  localparam int FW    = 2*DATA_W + SEL_W;
  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT+1) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              issue, capture, cnt_dec, xfer;
  logic [FW-1:0]     fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [SEL_W-1:0]  alu_sel_q, rsp_sel_q;
  logic              rsp_valid_q;

  alu_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .pop   (issue),
    .din   ({bus.cmd_a, bus.cmd_b, bus.cmd_sel}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.cmd_ready = !fifo_full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_sel   = rsp_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    capture  = 1'b0;
    cnt_dec  = 1'b0;
    xfer     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          issue    = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = ST_RESP;
        end else begin
          cnt_dec  = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          xfer = 1'b1;
          if (!fifo_empty) begin
            issue    = 1'b1;
            state_nx = ST_WAIT;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ALU inputs move only on an issue edge and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      cnt       <= '0;
    end else if (issue) begin
      {alu_a_q, alu_b_q, alu_sel_q} <= fifo_dout;
      cnt <= CNT_W'(ALU_LAT);
    end else if (cnt_dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Every accepted response clears valid; back-to-back issue re-raises it after the ALU latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= bus.alu_out;
      rsp_sel_q   <= alu_sel_q;
    end else if (xfer) begin
      rsp_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with an adder ALU stub (ALU_LAT=1) and a queue-based scoreboard.
module tb_alu_issue_stage;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   n_rsp;
  exp_t exp_q[$];
  int   xfer_cyc[$];

  alu_issue_if #(.DATA_W(32), .SEL_W(4)) bus ();

  alu_issue_stage #(.DATA_W(32), .SEL_W(4), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: registered adder
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.alu_out <= '0;
    else        bus.alu_out <= bus.alu_a + bus.alu_b;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshakes seen at the negedge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        xfer_cyc.push_back(cyc);
        n_rsp++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", bus.rsp_data, e.d);
          chk("rsp_sel", bus.rsp_sel, e.s);
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_t e;
        e.d = bus.cmd_a + bus.cmd_b;
        e.s = bus.cmd_sel;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    while (!bus.rsp_valid && k < max) begin
      tick();
      k++;
    end
    chk(tag, bus.rsp_valid, 1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && k < max) begin
      tick();
      k++;
    end
    chk(tag, (exp_q.size() == 0 && !bus.rsp_valid), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int changed;
    logic [31:0] s_data;
    logic [3:0]  s_sel;
    logic [31:0] s_a;
    n_chk = 0; n_fail = 0; cyc = 0; n_rsp = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
    bus.rsp_ready = 1'b0;
    #2;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_sel", bus.alu_sel, 0);
    #21 rst_n = 1'b1;
    tick();

    // single op timing
    push1(32'd5, 32'd2, 4'd1);
    chk("t1_e0_alu_a", bus.alu_a, 0);
    tick();
    chk("t1_alu_a", bus.alu_a, 5);
    chk("t1_alu_b", bus.alu_b, 2);
    chk("t1_alu_sel", bus.alu_sel, 1);
    chk("t1_e1_valid", bus.rsp_valid, 0);
    tick();
    chk("t1_e2_valid", bus.rsp_valid, 0);
    tick();
    chk("t1_e3_valid", bus.rsp_valid, 1);
    chk("t1_e3_data", bus.rsp_data, 7);
    chk("t1_e3_sel", bus.rsp_sel, 1);
    bus.rsp_ready = 1'b1;
    wait_drain("t1_drain", 20);

    // signed operands, in-order results
    push1(-32'sd10, 32'd13, 4'd8);
    push1(32'd10, 32'd5, 4'd8);
    wait_drain("t2_drain", 40);

    // full FIFO
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 32'(100 + i);
      bus.cmd_b = 32'(i);
      bus.cmd_sel = 4'(i + 1);
      @(negedge clk);
      chk($sformatf("t3_ready_%0d", i), bus.cmd_ready, (i < 5));
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("t3_accepted", exp_q.size(), 5);
    r0 = n_rsp;
    bus.rsp_ready = 1'b1;
    wait_drain("t3_drain", 60);
    chk("t3_returned", n_rsp - r0, 5);

    // backpressure
    bus.rsp_ready = 1'b0;
    push1(32'd7, 32'd9, 4'd3);
    push1(32'd1, 32'd1, 4'd4);
    wait_valid("t4_valid", 20);
    s_data = bus.rsp_data; s_sel = bus.rsp_sel; s_a = bus.alu_a;
    chk("t4_snap_data", s_data, 16);
    changed = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_data !== s_data || bus.rsp_sel !== s_sel || bus.alu_a !== s_a ||
          bus.alu_sel !== 4'd3 || !bus.rsp_valid) changed++;
    end
    chk("t4_stable", changed, 0);
    chk("t4_alu_a", bus.alu_a, 7);
    chk("t4_alu_sel", bus.alu_sel, 3);
    bus.rsp_ready = 1'b1;
    wait_drain("t4_drain", 40);

    // throughput
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push1(32'(1000 * i), 32'd3, 4'(i + 2));
    wait_valid("t5_valid", 20);
    xfer_cyc.delete();
    bus.rsp_ready = 1'b1;
    wait_drain("t5_drain", 60);
    chk("t5_count", xfer_cyc.size(), 4);
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk($sformatf("t5_gap_%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 3);

    // reset while waiting on the ALU
    bus.rsp_ready = 1'b0;
    push1(32'd40, 32'd2, 4'd5);
    tick();
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_cmd_ready", bus.cmd_ready, 1);
    chk("t6_alu_a", bus.alu_a, 0);
    chk("t6_alu_sel", bus.alu_sel, 0);
    #12 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_stale", bus.rsp_valid, 0);
    push1(32'd20, 32'd22, 4'd6);
    wait_drain("t6_drain", 20);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = $urandom_range(0, 1);
      bus.cmd_a = $urandom;
      bus.cmd_b = $urandom;
      bus.cmd_sel = 4'($urandom_range(1, 8));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain("rnd_drain", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
